// File: rtl/stream_demux2.sv
// ----------------------------------------------------------------------------
// stream_demux2
//
// Purpose:
//   Steers a single valid/ready input stream onto one of two output streams
//   (A or B). The destination of each word is either chosen explicitly by
//   select_i, or alternates A, B, A, B ... when mode_i is set. Each output
//   has its own 2-entry elastic buffer, so a stalled consumer only stalls the
//   input while it is the selected destination.
//
// Ports:
//   clk_i     - clock, all state updates on the rising edge
//   rst_i     - asynchronous active-high reset, clears all buffered state
//   data_i    - input word
//   valid_i   - input word present
//   select_i  - destination when mode_i=0 (0 = A, 1 = B)
//   mode_i    - 0 = explicit select, 1 = alternating A/B
//   ready_o   - input word is accepted this cycle if valid_i=1
//   dataA_o   - head word of buffer A
//   validA_o  - buffer A non-empty
//   readyA_i  - consumer A takes the head word this cycle
//   dataB_o   - head word of buffer B
//   validB_o  - buffer B non-empty
//   readyB_i  - consumer B takes the head word this cycle
//   countA_o  - occupancy of buffer A (0..2)
//   countB_o  - occupancy of buffer B (0..2)
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// stream_demux2_buf
//
// Purpose:
//   Two-entry FIFO used as the per-output elastic buffer. The head word comes
//   straight from registered storage, so there is never a combinational path
//   from the write side to the read side.
//
// Ports:
//   clk       - clock
//   rst       - asynchronous active-high reset
//   push      - write push_data this cycle (caller guarantees not full)
//   push_data - word to write
//   take      - consumer takes the head word this cycle (ignored when empty)
//   head      - word at the read pointer
//   valid     - buffer non-empty
//   count     - occupancy (0..2)
// ----------------------------------------------------------------------------
module stream_demux2_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             take,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] slot_q [0:1];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_next;
    logic             pop;

    // A take request on an empty buffer must not underflow, so the pop is
    // qualified by the buffer actually holding a word.
    assign valid = (count_q != 2'd0);
    assign pop   = valid && take;
    assign head  = slot_q[rd_ptr_q];
    assign count = count_q;

    // Occupancy moves by push minus pop; a simultaneous push and pop leaves
    // it unchanged.
    always_comb begin
        count_next = count_q;
        unique case ({push, pop})
            2'b10:   count_next = count_q + 2'd1;
            2'b01:   count_next = count_q - 2'd1;
            default: count_next = count_q;
        endcase
    end

    // Storage, pointers and count. Slots are cleared on reset so the head
    // word reads as zero straight after reset. The 1-bit pointers simply
    // toggle and therefore wrap from 1 back to 0 on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                slot_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                slot_q[wr_ptr_q] <= push_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_next;
        end
    end

endmodule

module stream_demux2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    input  logic             select_i,
    input  logic             mode_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] dataA_o,
    output logic             validA_o,
    input  logic             readyA_i,
    output logic [WIDTH-1:0] dataB_o,
    output logic             validB_o,
    input  logic             readyB_i,
    output logic [1:0]       countA_o,
    output logic [1:0]       countB_o
);

    typedef enum logic {
        TGT_A = 1'b0,
        TGT_B = 1'b1
    } target_e;

    target_e    rr_q;
    target_e    tgt;
    logic [1:0] tgt_count;
    logic       accept;
    logic       push_a;
    logic       push_b;

    // Destination of the current word: the round-robin pointer in
    // alternating mode, otherwise the explicit select.
    always_comb begin
        tgt = TGT_A;
        if (mode_i) begin
            tgt = rr_q;
        end else begin
            tgt = target_e'(select_i);
        end
    end

    // Readiness looks only at the selected buffer and never at valid_i. A
    // full buffer blocks the input even if its consumer pops this cycle,
    // which keeps ready_o free of any path from readyA_i/readyB_i.
    always_comb begin
        tgt_count = countA_o;
        if (tgt == TGT_B) begin
            tgt_count = countB_o;
        end
        ready_o = !rst_i && (tgt_count != 2'd2);
    end

    assign accept = valid_i && ready_o;
    assign push_a = accept && (tgt == TGT_A);
    assign push_b = accept && (tgt == TGT_B);

    // The alternation pointer only advances on words actually accepted in
    // alternating mode. Words routed explicitly leave it alone, so switching
    // back to alternating mode resumes where it left off.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q <= TGT_A;
        end else if (accept && mode_i) begin
            rr_q <= (rr_q == TGT_A) ? TGT_B : TGT_A;
        end
    end

    stream_demux2_buf #(
        .WIDTH (WIDTH)
    ) u_buf_a (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (push_a),
        .push_data (data_i),
        .take      (readyA_i),
        .head      (dataA_o),
        .valid     (validA_o),
        .count     (countA_o)
    );

    stream_demux2_buf #(
        .WIDTH (WIDTH)
    ) u_buf_b (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (push_b),
        .push_data (data_i),
        .take      (readyB_i),
        .head      (dataB_o),
        .valid     (validB_o),
        .count     (countB_o)
    );

endmodule

// File: tb/tb_stream_demux2.sv
// ----------------------------------------------------------------------------
// tb_stream_demux2
//
// Purpose:
//   Directed self-checking bench for stream_demux2. Inputs are driven 1 time
//   unit after each rising edge; outputs are compared 2 time units later,
//   well away from the next active edge.
// ----------------------------------------------------------------------------
module tb_stream_demux2;

    localparam int WIDTH = 8;

    logic             clk_i;
    logic             rst_i;
    logic [WIDTH-1:0] data_i;
    logic             valid_i;
    logic             select_i;
    logic             mode_i;
    logic             ready_o;
    logic [WIDTH-1:0] dataA_o;
    logic             validA_o;
    logic             readyA_i;
    logic [WIDTH-1:0] dataB_o;
    logic             validB_o;
    logic             readyB_i;
    logic [1:0]       countA_o;
    logic [1:0]       countB_o;

    int compared   = 0;
    int mismatched = 0;

    stream_demux2 #(
        .WIDTH (WIDTH)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .data_i   (data_i),
        .valid_i  (valid_i),
        .select_i (select_i),
        .mode_i   (mode_i),
        .ready_o  (ready_o),
        .dataA_o  (dataA_o),
        .validA_o (validA_o),
        .readyA_i (readyA_i),
        .dataB_o  (dataB_o),
        .validB_o (validB_o),
        .readyB_i (readyB_i),
        .countA_o (countA_o),
        .countB_o (countB_o)
    );

    // 10-unit clock, rising edges at 5, 15, 25 ...
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance past the next rising edge by one time unit.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive the input stream and let combinational outputs settle.
    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d,
                                 input logic sel, input logic md);
        valid_i  = v;
        data_i   = d;
        select_i = sel;
        mode_i   = md;
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Linear sequence of directed steps with hand-computed expectations.
    initial begin
        rst_i    = 1'b1;
        data_i   = '0;
        valid_i  = 1'b0;
        select_i = 1'b0;
        mode_i   = 1'b0;
        readyA_i = 1'b0;
        readyB_i = 1'b0;

        // ---- reset state ----
        tick();
        tick();
        #2;
        checkOutput("rst_ready",  ready_o,  0);
        checkOutput("rst_validA", validA_o, 0);
        checkOutput("rst_validB", validB_o, 0);
        checkOutput("rst_countA", countA_o, 0);
        checkOutput("rst_countB", countB_o, 0);
        checkOutput("rst_dataA",  dataA_o,  0);
        checkOutput("rst_dataB",  dataB_o,  0);
        tick();
        rst_i = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("post_rst_ready", ready_o, 1);

        // ---- explicit routing ----
        readyA_i = 1'b1;
        readyB_i = 1'b1;
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
        checkOutput("exp_ready0", ready_o, 1);
        tick();
        applyStimulus(1'b1, 8'h22, 1'b1, 1'b0);
        checkOutput("exp_validA_11", validA_o, 1);
        checkOutput("exp_dataA_11",  dataA_o,  8'h11);
        checkOutput("exp_validB_0",  validB_o, 0);
        tick();
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
        checkOutput("exp_validB_22", validB_o, 1);
        checkOutput("exp_dataB_22",  dataB_o,  8'h22);
        checkOutput("exp_validA_pop", validA_o, 0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("exp_validA_33", validA_o, 1);
        checkOutput("exp_dataA_33",  dataA_o,  8'h33);
        checkOutput("exp_validB_pop", validB_o, 0);
        tick();
        #2;
        checkOutput("exp_drained_countA", countA_o, 0);

        // ---- backpressure / full ----
        readyA_i = 1'b0;
        readyB_i = 1'b0;
        applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 8'hA2, 1'b0, 1'b0);
        checkOutput("bp_countA_1", countA_o, 1);
        checkOutput("bp_ready_1",  ready_o,  1);
        tick();
        applyStimulus(1'b1, 8'hA3, 1'b0, 1'b0);
        checkOutput("bp_countA_2", countA_o, 2);
        checkOutput("bp_ready_full", ready_o, 0);
        tick();
        #2;
        checkOutput("bp_hold_countA", countA_o, 2);
        checkOutput("bp_hold_dataA",  dataA_o,  8'hA1);

        // ---- independence: B still accepts while A is full ----
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
        checkOutput("ind_ready", ready_o, 1);
        tick();
        readyB_i = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("ind_validB", validB_o, 1);
        checkOutput("ind_dataB",  dataB_o,  8'h55);
        checkOutput("ind_countA", countA_o, 2);
        tick();
        #2;
        checkOutput("ind_validB_pop", validB_o, 0);

        // ---- drain A: full gives no pass-through, then push+pop ----
        readyA_i = 1'b1;
        applyStimulus(1'b1, 8'hA3, 1'b0, 1'b0);
        checkOutput("bp_no_passthru", ready_o, 0);
        tick();
        #2;
        checkOutput("bp_dataA_A2",   dataA_o,  8'hA2);
        checkOutput("bp_countA_pop", countA_o, 1);
        checkOutput("bp_ready_again", ready_o, 1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("pp_countA_keep", countA_o, 1);
        checkOutput("pp_dataA_A3",    dataA_o,  8'hA3);
        tick();
        #2;
        checkOutput("bp_empty_countA", countA_o, 0);
        tick();
        #2;
        checkOutput("underflow_countA", countA_o, 0);
        checkOutput("underflow_validA", validA_o, 0);

        // ---- round-robin, with an explicit word in between ----
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 8'h02, 1'b0, 1'b1);
        checkOutput("rr_dataA_01", dataA_o, 8'h01);
        checkOutput("rr_validB_0", validB_o, 0);
        tick();
        applyStimulus(1'b1, 8'h03, 1'b0, 1'b1);
        checkOutput("rr_dataB_02", dataB_o, 8'h02);
        checkOutput("rr_validA_0", validA_o, 0);
        tick();
        applyStimulus(1'b1, 8'h04, 1'b0, 1'b1);
        checkOutput("rr_dataA_03", dataA_o, 8'h03);
        checkOutput("rr_validB_1", validB_o, 0);
        tick();
        applyStimulus(1'b1, 8'h05, 1'b1, 1'b0);
        checkOutput("rr_dataB_04", dataB_o, 8'h04);
        checkOutput("rr_validA_2", validA_o, 0);
        tick();
        applyStimulus(1'b1, 8'h06, 1'b0, 1'b1);
        checkOutput("rr_dataB_05", dataB_o, 8'h05);
        checkOutput("rr_validA_3", validA_o, 0);
        tick();
        applyStimulus(1'b1, 8'h07, 1'b0, 1'b1);
        checkOutput("rr_resume_validA", validA_o, 1);
        checkOutput("rr_resume_dataA",  dataA_o,  8'h06);
        checkOutput("rr_resume_validB", validB_o, 0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("rr_resume_dataB", dataB_o, 8'h07);
        checkOutput("rr_resume_validB2", validB_o, 1);
        tick();

        // ---- asynchronous reset with A holding two words ----
        readyA_i = 1'b0;
        readyB_i = 1'b0;
        applyStimulus(1'b1, 8'h81, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 8'h82, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("mid_countA_2", countA_o, 2);
        rst_i = 1'b1;
        #1;
        checkOutput("async_validA", validA_o, 0);
        checkOutput("async_countA", countA_o, 0);
        checkOutput("async_ready",  ready_o,  0);
        tick();
        tick();
        rst_i = 1'b0;
        #2;
        checkOutput("rel_ready",  ready_o,  1);
        checkOutput("rel_dataA",  dataA_o,  0);
        checkOutput("rel_countA", countA_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
